// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg: shared state encoding and sizing helpers for the round-robin
// multiplier arbiter.
package booth_arb_pkg;

  localparam int OP_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Index width that stays at least one bit wide for NUM_REQ == 2.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/booth_rr_grant.sv
// booth_rr_grant: combinational round-robin find-first, searching from ptr+1
// with wrap-around, so the last winner has lowest priority.
module booth_rr_grant
  import booth_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [IW-1:0] j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = j;
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sharing of one booths_multiplier among NUM_REQ
// requesters. Define BOOTH_ARB_TIMEOUT_EN for the WAIT timeout and err port.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int OP_W           = OP_W_DEF,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int GW             = idx_w(NUM_REQ)
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*OP_W-1:0] a_in,
  input  logic [NUM_REQ*OP_W-1:0] b_in,
  output logic [NUM_REQ-1:0]      ack,
  output logic [2*OP_W-1:0]       r_out,
  output logic [GW-1:0]           grant_id,
  output logic                    busy,
  output logic                    mul_start,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic [2*OP_W-1:0]       mul_r,
  input  logic                    mul_ready
`ifdef BOOTH_ARB_TIMEOUT_EN
  ,
  output logic                    err
`endif
);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("booth_mul_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e state, nstate;

  logic [NUM_REQ-1:0][OP_W-1:0] a_v, b_v;
  logic [NUM_REQ-1:0]           g_oh, gnt_oh;
  logic [GW-1:0]                g_idx, ptr;
  logic                         g_any, armed, mul_done, to_hit;

  assign a_v = a_in;
  assign b_v = b_in;

  booth_rr_grant #(.NUM_REQ(NUM_REQ), .IW(GW)) u_rr (
    .req    (req),
    .ptr    (ptr),
    .onehot (g_oh),
    .idx    (g_idx),
    .any    (g_any)
  );

  // A ready that was already high at ISSUE belongs to the previous op; only a
  // ready seen after a low cycle completes this one.
  assign mul_done = armed && mul_ready;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          to_flag;
  assign to_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (g_any) nstate = ISSUE;
      ISSUE:   nstate = WAIT;
      WAIT:    if (mul_done || to_hit) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    mul_start = (state == ISSUE);
    busy      = (state != IDLE);
    ack       = (state == DONE) ? gnt_oh : '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
    err       = (state == DONE) && to_flag;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= GW'(NUM_REQ - 1);
      grant_id <= '0;
      gnt_oh   <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      r_out    <= '0;
      armed    <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      wait_cnt <= '0;
      to_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (g_any) begin
          mul_a    <= a_v[g_idx];
          mul_b    <= b_v[g_idx];
          grant_id <= g_idx;
          gnt_oh   <= g_oh;
          ptr      <= g_idx;
        end
        ISSUE: begin
          armed <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
          wait_cnt <= '0;
          to_flag  <= 1'b0;
`endif
        end
        WAIT: begin
          if (!mul_ready) armed <= 1'b1;
          if (mul_done) r_out <= mul_r;
`ifdef BOOTH_ARB_TIMEOUT_EN
          else if (to_hit) begin
            r_out   <= '0;
            to_flag <= 1'b1;
          end else wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
